// File: rtl/alu_issue_queue_if.sv
// Command, ALU-drive and result handshake bundle between the issue queue and its neighbours.
// The slave view belongs to the queue; the master view belongs to the command source, the ALU and the result sink.
interface alu_issue_queue_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_op;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic [1:0]        alu_op_code;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_result;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_result;
  logic [1:0]        out_op;

  modport master (
    output in_valid, in_op, in_a, in_b, alu_result, out_ready,
    input  in_ready, alu_op_code, alu_a, alu_b, out_valid, out_result, out_op
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, alu_result, out_ready,
    output in_ready, alu_op_code, alu_a, alu_b, out_valid, out_result, out_op
  );
endinterface

// File: rtl/alu_issue_queue.sv
// Command FIFO in front of a combinational 4-function ALU, with a registered
// valid/ready result slot and a count of results handed downstream.
module alu_issue_queue #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  alu_issue_queue_if.slave bus,
  output logic [LVL_W-1:0] o_level,
  output logic [CNT_W-1:0] o_done_count
);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  logic [1:0]        r_fifo_op [DEPTH];
  logic [DATA_W-1:0] r_fifo_a  [DEPTH];
  logic [DATA_W-1:0] r_fifo_b  [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [LVL_W-1:0]  r_level;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_result;
  logic [1:0]        r_out_op;
  logic [CNT_W-1:0]  r_done_count;

  logic w_empty;
  logic w_full;
  logic w_slot_free;
  logic w_push;
  logic w_pop;
  logic w_handshake;

  assign w_empty     = (r_level == '0);
  assign w_full      = (r_level == FULL_LVL);
  assign w_slot_free = !r_out_valid || bus.out_ready;
  assign w_push      = bus.in_valid && !w_full;
  assign w_pop       = !w_empty && w_slot_free;
  assign w_handshake = r_out_valid && bus.out_ready;

  // Readiness deliberately ignores a same-cycle pop to keep in_ready off the out_ready path.
  assign bus.in_ready    = !w_full;
  assign bus.alu_op_code = w_empty ? 2'b00 : r_fifo_op[r_rd_ptr];
  assign bus.alu_a       = w_empty ? '0 : r_fifo_a[r_rd_ptr];
  assign bus.alu_b       = w_empty ? '0 : r_fifo_b[r_rd_ptr];
  assign bus.out_valid   = r_out_valid;
  assign bus.out_result  = r_out_result;
  assign bus.out_op      = r_out_op;
  assign o_level         = r_level;
  assign o_done_count    = r_done_count;

  // Entry storage needs no reset: only slots between the pointers are ever read.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && !i_flush && w_push) begin
      r_fifo_op[r_wr_ptr] <= bus.in_op;
      r_fifo_a[r_wr_ptr]  <= bus.in_a;
      r_fifo_b[r_wr_ptr]  <= bus.in_b;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_level      <= '0;
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
      r_out_op     <= 2'b00;
      r_done_count <= '0;
    end else begin
      if (w_handshake) begin
        r_done_count <= r_done_count + CNT_W'(1);
      end
      if (i_flush) begin
        r_wr_ptr    <= '0;
        r_rd_ptr    <= '0;
        r_level     <= '0;
        r_out_valid <= 1'b0;
      end else begin
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        end
        if (w_pop) begin
          r_rd_ptr     <= r_rd_ptr + PTR_W'(1);
          r_out_valid  <= 1'b1;
          r_out_result <= bus.alu_result;
          r_out_op     <= r_fifo_op[r_rd_ptr];
        end else if (w_slot_free) begin
          r_out_valid <= 1'b0;
        end
        case ({w_push, w_pop})
          2'b10:   r_level <= r_level + LVL_W'(1);
          2'b01:   r_level <= r_level - LVL_W'(1);
          default: r_level <= r_level;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed bench for alu_issue_queue: vector table plus hand-written multi-cycle sequences,
// with a negedge scoreboard checking every result handed downstream.
module tb_alu_issue_queue;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int CW    = 4;

  typedef struct {
    logic [1:0]    op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] res;
  } vec_t;

  typedef struct packed {
    logic [1:0]    op;
    logic [DW-1:0] res;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic [2:0]    level;
  logic [CW-1:0] done_count;

  vec_t       tbl [8];
  exp_t       q [$];
  logic [CW-1:0] exp_done;
  int         n_total = 0;
  int         n_pass  = 0;

  alu_issue_queue_if #(.DATA_W(DW)) bus ();

  alu_issue_queue #(.DATA_W(DW), .DEPTH(DEPTH), .CNT_W(CW)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_flush      (flush),
    .bus          (bus),
    .o_level      (level),
    .o_done_count (done_count)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] alu_ref(logic [1:0] op, logic [DW-1:0] a, logic [DW-1:0] b);
    case (op)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a & b;
      default: return a | b;
    endcase
  endfunction

  always_comb bus.alu_result = alu_ref(bus.alu_op_code, bus.alu_a, bus.alu_b);

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // A handshake seen here completes at the next rising edge.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) begin
        check("spurious_result", 32'(bus.out_result), 32'hFFFF_FFFF);
      end else begin
        e = q.pop_front();
        check("sb_result", 32'(bus.out_result), 32'(e.res));
        check("sb_op", 32'(bus.out_op), 32'(e.op));
      end
      exp_done = exp_done + CW'(1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(logic [1:0] op, logic [DW-1:0] a, logic [DW-1:0] b, logic [DW-1:0] res);
    bit ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_a     = a;
    bus.in_b     = b;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (bus.in_ready) begin
        q.push_back(exp_t'({op, res}));
        ok = 1'b1;
      end
      tick();
    end
    bus.in_valid = 1'b0;
    if (!ok) check("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    bit idle = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 60 && !idle; i++) begin
      tick();
      idle = (level == 3'd0) && !bus.out_valid;
    end
    check("drain_idle", 32'(idle), 32'd1);
    check("drain_queue_empty", 32'(q.size()), 32'd0);
    check("drain_done_count", 32'(done_count), 32'(exp_done));
  endtask

  task automatic check_reset_state(string tag);
    check({tag, "_level"}, 32'(level), 32'd0);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_out_result"}, 32'(bus.out_result), 32'd0);
    check({tag, "_out_op"}, 32'(bus.out_op), 32'd0);
    check({tag, "_done_count"}, 32'(done_count), 32'd0);
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    check({tag, "_alu_a"}, 32'(bus.alu_a), 32'd0);
  endtask

  initial begin
    tbl[0] = '{2'd0, 8'hFF, 8'h02, 8'h01};
    tbl[1] = '{2'd1, 8'h00, 8'h01, 8'hFF};
    tbl[2] = '{2'd2, 8'hF0, 8'h3C, 8'h30};
    tbl[3] = '{2'd3, 8'h0F, 8'h30, 8'h3F};
    tbl[4] = '{2'd1, 8'h10, 8'h20, 8'hF0};
    tbl[5] = '{2'd0, 8'h7F, 8'h01, 8'h80};
    tbl[6] = '{2'd2, 8'hAA, 8'h55, 8'h00};
    tbl[7] = '{2'd3, 8'hA5, 8'h5A, 8'hFF};

    rst_n = 1'b0; flush = 1'b0; exp_done = '0;
    bus.in_valid = 1'b0; bus.in_op = 2'd0; bus.in_a = '0; bus.in_b = '0;
    bus.out_ready = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    check_reset_state("rst");

    // Single add: pushed at edge t, captured at t+1, taken at t+2.
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.in_op = 2'd0; bus.in_a = 8'h0F; bus.in_b = 8'h01;
    q.push_back(exp_t'({2'd0, 8'h10}));
    tick();
    bus.in_valid = 1'b0;
    check("s1_level", 32'(level), 32'd1);
    check("s1_no_bypass", 32'(bus.out_valid), 32'd0);
    check("s1_alu_a", 32'(bus.alu_a), 32'h0F);
    check("s1_alu_b", 32'(bus.alu_b), 32'h01);
    tick();
    check("s1_out_valid", 32'(bus.out_valid), 32'd1);
    check("s1_out_result", 32'(bus.out_result), 32'h10);
    check("s1_out_op", 32'(bus.out_op), 32'd0);
    tick();
    check("s1_done_count", 32'(done_count), 32'd1);
    check("s1_slot_empty", 32'(bus.out_valid), 32'd0);

    // Back-to-back table vectors: one result per cycle, level pinned at 1 by push+pop.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      push(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].res);
      if (i > 0) begin
        check("s2_throughput_valid", 32'(bus.out_valid), 32'd1);
        check("s2_pushpop_level", 32'(level), 32'd1);
      end
    end
    drain();
    check("s2_done_count", 32'(done_count), 32'd9);

    // Backpressure until full, then release.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push(2'(i), 8'(i * 17 + 1), 8'(i * 5 + 3), alu_ref(2'(i), 8'(i * 17 + 1), 8'(i * 5 + 3)));
    end
    check("s3_full_level", 32'(level), 32'd4);
    check("s3_full_in_ready", 32'(bus.in_ready), 32'd0);
    check("s3_slot_valid", 32'(bus.out_valid), 32'd1);
    check("s3_slot_result", 32'(bus.out_result), 32'h04);
    bus.in_valid = 1'b1; bus.in_op = 2'd1; bus.in_a = 8'hEE; bus.in_b = 8'h03;
    tick();
    check("s3_full_hold_level", 32'(level), 32'd4);
    check("s3_full_hold_ready", 32'(bus.in_ready), 32'd0);
    bus.out_ready = 1'b1;
    check("s3_no_push_on_pop", 32'(bus.in_ready), 32'd0);
    push(2'd1, 8'h40, 8'h03, 8'h3D);
    drain();
    check("s3_done_count", 32'(done_count), 32'd15);

    // Flush with level 3 and a stalled result in the slot.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].res);
    end
    check("s5_pre_level", 32'(level), 32'd3);
    check("s5_pre_valid", 32'(bus.out_valid), 32'd1);
    flush = 1'b1;
    bus.in_valid = 1'b1; bus.in_op = 2'd3; bus.in_a = 8'h11; bus.in_b = 8'h22;
    tick();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    q.delete();
    check("s5_level", 32'(level), 32'd0);
    check("s5_out_valid", 32'(bus.out_valid), 32'd0);
    check("s5_alu_a", 32'(bus.alu_a), 32'd0);
    check("s5_alu_b", 32'(bus.alu_b), 32'd0);
    check("s5_alu_op", 32'(bus.alu_op_code), 32'd0);
    check("s5_in_ready", 32'(bus.in_ready), 32'd1);
    check("s5_done_kept", 32'(done_count), 32'd15);
    tick();
    check("s5_push_discarded", 32'(level), 32'd0);

    // Flush on the same edge as a handshake: the handshake still counts (15 -> 16 wraps to 0).
    push(tbl[5].op, tbl[5].a, tbl[5].b, tbl[5].res);
    tick();
    check("s5b_valid", 32'(bus.out_valid), 32'd1);
    bus.out_ready = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("s5b_done_wrap", 32'(done_count), 32'(exp_done));
    check("s5b_done_zero", 32'(done_count), 32'd0);
    check("s5b_out_valid", 32'(bus.out_valid), 32'd0);

    // Mid-stream reset with level 2, then the single-op sequence again.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push(tbl[i + 4].op, tbl[i + 4].a, tbl[i + 4].b, tbl[i + 4].res);
    end
    check("s6_pre_level", 32'(level), 32'd2);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    q.delete();
    exp_done = '0;
    check_reset_state("s6");
    bus.out_ready = 1'b1;
    push(2'd0, 8'h0F, 8'h01, 8'h10);
    tick();
    check("s6_out_result", 32'(bus.out_result), 32'h10);
    drain();
    check("s6_done_one", 32'(done_count), 32'd1);

    // Fifteen more results bring the 4-bit counter to 16, i.e. 0.
    for (int i = 0; i < 15; i++) begin
      push(tbl[i % 8].op, tbl[i % 8].a, tbl[i % 8].b, tbl[i % 8].res);
    end
    drain();
    check("s6_done_wrap", 32'(done_count), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/alu_issue_queue.md
Name: alu_issue_queue

Overview:
Upstream operand-staging stage for the 4-function combinational ALU (add, sub, and, or).
- Accepts ALU commands (op, a, b) over a valid/ready interface and buffers them in a DEPTH-entry FIFO.
- Drives the FIFO head onto the ALU operand and op-code inputs.
- Captures the ALU result into a registered valid/ready output slot, tagged with its op code.
- Sustains one operation per cycle; absorbs upstream and downstream stalls.

Parameters:
DATA_W, 8, operand and result width; must match the ALU width.
DEPTH, 4, FIFO entries; a power of 2, minimum 2.
CNT_W, 16, width of the completed-operation counter.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst_n  input  1  synchronous active-low reset.
flush  input  1  synchronous clear of the FIFO and the output slot.
in_valid  input  1  command valid.
in_ready  output  1  command accepted when in_valid && in_ready; equals !full.
in_op  input  2  00 add, 01 sub, 10 and, 11 or.
in_a  input  DATA_W  operand a.
in_b  input  DATA_W  operand b.
alu_op_code  output  2  to the ALU op_code input; head entry op.
alu_a  output  DATA_W  to the ALU a input; head entry a.
alu_b  output  DATA_W  to the ALU b input; head entry b.
alu_result  input  DATA_W  combinational ALU result for the alu_* values.
out_valid  output  1  result slot holds a valid result.
out_ready  input  1  downstream takes the result when out_valid && out_ready.
out_result  output  DATA_W  registered ALU result.
out_op  output  2  op code that produced out_result.
level  output  clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH.
done_count  output  CNT_W  number of results handed downstream; wraps modulo 2^CNT_W.

Behaviour:
- Reset (rst_n=0 at a clock edge) has priority over everything else. After reset:
  - FIFO empty: level=0, read and write pointers 0.
  - out_valid=0, out_result=0, out_op=0, done_count=0.
  - in_ready=1.
- Push: in_valid && in_ready writes {in_op, in_a, in_b} at the write pointer. The pointer wraps from DEPTH-1 to 0.
- full = (level==DEPTH); in_ready = !full.
  - in_ready does not depend on a same-cycle pop. When full, a push is refused even if a pop occurs that cycle.
- ALU drive is combinational from the head entry: alu_op_code/alu_a/alu_b = head fields when level>0, and all-zero when empty.
- slot_free = !out_valid || out_ready.
- Issue: when level>0 && slot_free, at the clock edge:
  - out_result <= alu_result, out_op <= head op, out_valid <= 1;
  - pop the head; the read pointer wraps.
- When slot_free && level==0: out_valid <= 0. out_result and out_op hold their values.
- When out_valid && !out_ready: the slot holds, and the FIFO does not pop.
- done_count increments by 1 on every edge where out_valid && out_ready. It wraps from 2^CNT_W-1 to 0.
- Simultaneous push and pop: level is unchanged.
  - This is legal at any non-full level, including level=1. The pushed entry becomes the new head next cycle.
- Latency: a command pushed at edge t, into an empty FIFO with a free slot, is captured at edge t+1. out_valid is therefore high in the cycle after edge t+1.
  - No combinational bypass from in_* to the alu_* outputs.
- Throughput: one result per cycle while out_ready=1 and the FIFO is non-empty.
- Arithmetic: the ALU result is taken as-is, DATA_W bits.
  - Add and sub wrap modulo 2^DATA_W; there is no carry or borrow output.
  - This block does no arithmetic of its own.
- flush=1 at an edge (with rst_n=1):
  - level=0, pointers 0, out_valid=0;
  - any push or issue in that cycle is discarded;
  - done_count is not cleared;
  - a handshake of the out_valid && out_ready that held before the edge still counts.
- in_op, in_a and in_b are sampled only on push. Changes to them while in_ready=0 have no effect.
- Reset asserted mid-stream discards all queued and in-slot results. No partial state survives.

Test Plan:
1. Reset then single op: push add 8'h0F+8'h01 with out_ready=1 -> out_valid rises 2 cycles after push; out_result=8'h10, out_op=00, done_count=1.
2. Wrap arithmetic: push add FF+02, sub 00-01, and F0&3C, or 0F|30 back-to-back -> results 01, FF, 30, 3F in order, one per cycle; done_count=4.
3. Backpressure and full: hold out_ready=0 and push 6 commands. Expect:
   - slot captures command 1; FIFO fills to level=4; in_ready=0 and the 6th command waits;
   - then release out_ready=1 -> all 6 results emerge in order, with no loss or duplication.
4. Simultaneous push and pop at level=1 -> level remains 1; the result order is preserved.
5. Flush with level=3 and out_valid=1 while out_ready=0 -> next cycle level=0, out_valid=0, alu_a=alu_b=0; done_count unchanged.
6. Mid-stream reset: rst_n=0 for 1 cycle with level=2 -> all outputs at reset values, in_ready=1; a subsequent push sequence behaves as in scenario 1. Also check done_count wrap with CNT_W=4: 16 results -> done_count=0.
